rgb2dram: RTL and testbench
===========================

// Module: rgb2dram
// PURPOSE
//  Frame writer: opposite direction of the DRAM-to-RGB reader. Buffers 32-bit RGB words from the
//  pixel pipeline and issues fixed-size write bursts to the DRAM write engine (kick/busy handshake),
//  while the engine pulls data from the internal FIFO. A frame is written linearly into one of two buffers.
// PARAMETERS
//  AMOUNT_OF_ONCE   32'd64       words per DRAM write burst; driven on write_num
//  OFFSET_END       32'd1440000  words per frame (1600x900); must be a multiple of AMOUNT_OF_ONCE
//  FIFO_AW          9            FIFO address width (depth 512); depth must be >= 2*AMOUNT_OF_ONCE
// PORTS
//  clk          in   1   single clock for all logic
//  rst_n        in   1   reset, asynchronous, active-low
//  start        in   1   1-cycle pulse: arm a new frame; samples frame_select
//  frame_select in   1   1: base 32'h0, 0: base 32'h100_0000
//  ready        out  1   high while armed (S_WAIT/S_KICK/S_BURST)
//  final        out  1   high in S_END (frame completely written)
//  rgb_in       in   32  pixel word
//  rgb_we       in   1   push rgb_in
//  rgb_full     out  1   registered prog-full: FIFO count >= 2**FIFO_AW-4
//  overflow     out  1   sticky: rgb_we while FIFO truly full (word dropped)
//  underflow    out  1   sticky: buf_re while FIFO empty
//  kick         out  1   burst request
//  busy         in   1   DRAM write engine busy
//  write_num    out  32  = AMOUNT_OF_ONCE (constant)
//  write_addr   out  32  byte address of current burst = base + (offset<<2), stable S_KICK..S_BURST
//  buf_din      out  32  FIFO head word (first-word-fall-through)
//  buf_re       in   1   engine pops one word
// BEHAVIOUR
//  Reset: state=S_IDLE, kick/ready/final/overflow/underflow/rgb_full=0, offset=0, base=0, FIFO flushed.
//  States:
//   S_IDLE : start -> latch base from frame_select, offset<=0, flush FIFO, -> S_WAIT
//   S_WAIT : count >= AMOUNT_OF_ONCE && !busy -> S_KICK
//   S_KICK : kick=1; first cycle busy=1 -> kick drops next cycle, burst_cnt<=0, -> S_BURST
//   S_BURST: burst_cnt counts buf_re; burst_cnt==AMOUNT_OF_ONCE && !busy -> offset+=AMOUNT_OF_ONCE;
//            if new offset==OFFSET_END -> S_END else -> S_WAIT
//   S_END  : final=1; start -> same as S_IDLE start (new frame); else hold
//  Pixels accepted only while ready=1; rgb_we otherwise ignored (no flag).
//  FIFO: buf_din valid whenever count>0; push+pop same cycle -> count unchanged, both take effect.
//  Push when count==depth -> word dropped, overflow<=1. Pop when empty -> no pointer move, underflow<=1.
//  buf_re beyond AMOUNT_OF_ONCE in one burst still pops; burst_cnt saturates (engine contract violation).
//  start while ready=1: ignored. offset width 32, no wrap; sticky flags clear only on reset or start.
//  Latency: word written in cycle N is visible on buf_din in cycle N+1.
// CONFIGURATION
//  RGB2DRAM_STATS_EN defined: adds out ports frame_cnt[15:0] (+1 on each S_BURST->S_END) and
//   drop_cnt[15:0] (+1 per overflow drop, saturating at 16'hFFFF); both reset to 0 by rst_n only.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package rgb2dram_pkg: state enum (S_IDLE..S_END), BASE_FRAME0=32'h0, BASE_FRAME1=32'h100_0000.
//  Sub-module rgb2dram_fifo: single-clock FWFT FIFO, async active-low reset plus sync flush,
//   outputs count[FIFO_AW:0]; FSM, address and flags stay in rgb2dram.
// TESTING
//  1 start, frame_select=1; push 64 words -> kick=1 with write_addr=0; busy 1 cycle later -> kick=0.
//  2 engine pops 64 words (buf_din = pushed order), busy low -> offset=64, next write_addr=0x100.
//  3 OFFSET_END=128 override, frame_select=0: two bursts -> write_addrs 0x100_0000, 0x100_0100; final=1.
//  4 fill 512 words with engine stalled, push 1 more -> overflow=1, word dropped, drop_cnt=1 (STATS_EN).
//  5 buf_re with FIFO empty -> underflow=1, count stays 0; simultaneous push+pop at count=10 -> count=10.
//  6 assert rst_n low mid-S_BURST -> kick=0, ready=0, FIFO empty asynchronously; start re-arms cleanly.

Source files
------------

// File: rtl/rgb2dram_pkg.sv
// rgb2dram shared types: FSM states and frame base addresses.
package rgb2dram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_KICK,
        S_BURST,
        S_END
    } state_t;

    localparam logic [31:0] BASE_FRAME0 = 32'h0;
    localparam logic [31:0] BASE_FRAME1 = 32'h100_0000;

    function automatic logic [31:0] frame_base(input logic sel);
        return sel ? BASE_FRAME0 : BASE_FRAME1;
    endfunction

endpackage

// File: rtl/rgb2dram_fifo.sv
// rgb2dram_fifo: single-clock first-word-fall-through FIFO with
// async reset and synchronous flush; count is depth-inclusive.
module rgb2dram_fifo #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          we,
    input  logic [DW-1:0] din,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = count[AW];
    assign empty = (count == '0);
    assign do_wr = we && !full;
    assign do_rd = re && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd) count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end

    // storage carries no reset; only pointers define content
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rgb2dram.sv
// rgb2dram: frame writer feeding fixed-size DRAM write bursts from a FIFO.
// Define RGB2DRAM_STATS_EN to add frame_cnt/drop_cnt statistics ports.
module rgb2dram
    import rgb2dram_pkg::*;
#(
    parameter logic [31:0] AMOUNT_OF_ONCE = 32'd64,
    parameter logic [31:0] OFFSET_END     = 32'd1440000,
    parameter int          FIFO_AW        = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        frame_select,
    output logic        ready,
    output logic        frame_final,
    input  logic [31:0] rgb_in,
    input  logic        rgb_we,
    output logic        rgb_full,
    output logic        overflow,
    output logic        underflow,
    output logic        kick,
    input  logic        busy,
    output logic [31:0] write_num,
    output logic [31:0] write_addr,
    output logic [31:0] buf_din,
    input  logic        buf_re
`ifdef RGB2DRAM_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PFULL_LVL = (FIFO_AW+1)'(DEPTH - 4);
    localparam logic [FIFO_AW:0] BURST_LVL = (FIFO_AW+1)'(AMOUNT_OF_ONCE);

    state_t           state;
    state_t           nxt;
    logic [31:0]      base;
    logic [31:0]      offset;
    logic [31:0]      burst_cnt;
    logic [FIFO_AW:0] count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             arm;
    logic             fifo_we;
    logic             burst_done;

    assign arm        = start && (state == S_IDLE || state == S_END);
    assign fifo_we    = rgb_we && ready;
    assign burst_done = (burst_cnt == AMOUNT_OF_ONCE) && !busy;
    assign write_num  = AMOUNT_OF_ONCE;
    assign write_addr = base + (offset << 2);

    rgb2dram_fifo #(
        .AW(FIFO_AW),
        .DW(32)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(arm),
        .we   (fifo_we),
        .din  (rgb_in),
        .re   (buf_re),
        .dout (buf_din),
        .count(count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = S_WAIT;
            S_WAIT:  if (count >= BURST_LVL && !busy) nxt = S_KICK;
            S_KICK:  if (busy) nxt = S_BURST;
            S_BURST: if (burst_done)
                nxt = (offset + AMOUNT_OF_ONCE == OFFSET_END) ? S_END : S_WAIT;
            S_END:   if (start) nxt = S_WAIT;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        kick        = 1'b0;
        ready       = 1'b0;
        frame_final = 1'b0;
        unique case (1'b1)
            (state == S_KICK): begin
                kick  = 1'b1;
                ready = 1'b1;
            end
            (state == S_WAIT),
            (state == S_BURST): ready = 1'b1;
            (state == S_END):   frame_final = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            offset    <= '0;
            burst_cnt <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rgb_full  <= 1'b0;
        end else begin
            rgb_full <= (count >= PFULL_LVL);
            if (arm) begin
                base      <= frame_base(frame_select);
                offset    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (fifo_we && fifo_full) overflow <= 1'b1;
                if (buf_re && fifo_empty) underflow <= 1'b1;
                if (state == S_BURST && burst_done)
                    offset <= offset + AMOUNT_OF_ONCE;
            end
            // excess pops in a burst still drain the FIFO but never wrap the count
            if (state == S_KICK)
                burst_cnt <= '0;
            else if (state == S_BURST && buf_re && burst_cnt != AMOUNT_OF_ONCE)
                burst_cnt <= burst_cnt + 1'b1;
        end
    end

`ifdef RGB2DRAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (state == S_BURST && nxt == S_END)
                frame_cnt <= frame_cnt + 1'b1;
            if (fifo_we && fifo_full && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rgb2dram.sv
// tb_rgb2dram: randomized frames against a queue-based reference model,
// with a negedge monitor scoring FIFO data and burst addresses.
module tb_rgb2dram;

    localparam int AMT    = 64;
    localparam int OEND   = 128;
    localparam int DEPTH  = 512;
    localparam int BURSTS = OEND / AMT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        frame_select;
    logic        ready;
    logic        frame_final;
    logic [31:0] rgb_in;
    logic        rgb_we;
    logic        rgb_full;
    logic        overflow;
    logic        underflow;
    logic        kick;
    logic        busy;
    logic [31:0] write_num;
    logic [31:0] write_addr;
    logic [31:0] buf_din;
    logic        buf_re;
`ifdef RGB2DRAM_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] base_m;
    int          bursts_m;
    bit          armed;
    int          frames_m;
    int          drops_m;
    bit          kick_d;

    always #5 clk = ~clk;

    rgb2dram #(
        .AMOUNT_OF_ONCE(32'd64),
        .OFFSET_END    (32'd128),
        .FIFO_AW       (9)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .frame_select(frame_select),
        .ready       (ready),
        .frame_final (frame_final),
        .rgb_in      (rgb_in),
        .rgb_we      (rgb_we),
        .rgb_full    (rgb_full),
        .overflow    (overflow),
        .underflow   (underflow),
        .kick        (kick),
        .busy        (busy),
        .write_num   (write_num),
        .write_addr  (write_addr),
        .buf_din     (buf_din),
        .buf_re      (buf_re)
`ifdef RGB2DRAM_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: scores every popped word and every burst request
    always @(negedge clk) begin
        if (!rst_n) begin
            kick_d = 1'b0;
        end else begin
            if (buf_re && exp_data.size() > 0)
                chk("buf_din", buf_din, exp_data.pop_front());
            if (kick && !kick_d) begin
                if (exp_addr.size() > 0) begin
                    chk("kick_addr", write_addr, exp_addr.pop_front());
                end else begin
                    total++;
                    bad++;
                    $display("FAIL kick_unexpected: got addr %h want none",
                             write_addr);
                end
            end
            kick_d = kick;
        end
    end

    task automatic start_frame(input logic fs);
        frame_select = fs;
        start = 1'b1;
        exp_data.delete();
        exp_addr.delete();
        base_m = fs ? 32'h0 : 32'h0100_0000;
        for (int i = 0; i < BURSTS; i++)
            exp_addr.push_back(base_m + 32'(i * AMT * 4));
        armed = 1'b1;
        bursts_m = 0;
        step();
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        rgb_in = w;
        rgb_we = 1'b1;
        if (armed) begin
            if (exp_data.size() < DEPTH) exp_data.push_back(w);
            else drops_m++;
        end
        step();
        rgb_we = 1'b0;
    endtask

    task automatic wait_kick();
        int n = 0;
        while (kick !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (kick !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL kick_timeout: got kick=%b want 1", kick);
        end
    endtask

    task automatic do_burst();
        wait_kick();
        busy = 1'b1;
        step();
        chk("kick_drop", {31'b0, kick}, 32'd0);
        chk("ready_burst", {31'b0, ready}, 32'd1);
        buf_re = 1'b1;
        repeat (AMT) step();
        buf_re = 1'b0;
        busy = 1'b0;
        step();
        bursts_m++;
        chk("next_addr", write_addr, base_m + 32'(bursts_m * AMT * 4));
        if (bursts_m == BURSTS) begin
            armed = 1'b0;
            frames_m++;
            chk("final_hi", {31'b0, frame_final}, 32'd1);
            chk("ready_end", {31'b0, ready}, 32'd0);
        end else begin
            chk("final_lo", {31'b0, frame_final}, 32'd0);
        end
    endtask

    task automatic check_stats();
`ifdef RGB2DRAM_STATS_EN
        chk("frame_cnt", {16'b0, frame_cnt}, 32'(frames_m));
        chk("drop_cnt", {16'b0, drop_cnt}, 32'(drops_m));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        frame_select = 1'b0;
        rgb_in = '0;
        rgb_we = 1'b0;
        busy = 1'b0;
        buf_re = 1'b0;
        armed = 1'b0;
        frames_m = 0;
        drops_m = 0;
        bursts_m = 0;
        base_m = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_kick", {31'b0, kick}, 32'd0);
        chk("rst_final", {31'b0, frame_final}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_unf", {31'b0, underflow}, 32'd0);
        chk("rst_full", {31'b0, rgb_full}, 32'd0);
        chk("rst_addr", write_addr, 32'd0);
        chk("write_num", write_num, 32'd64);
        check_stats();

        // frame 1 base, bursts fed one at a time
        start_frame(1'b1);
        chk("ready_arm", {31'b0, ready}, 32'd1);
        repeat (AMT) push($urandom);
        do_burst();
        repeat (AMT) push($urandom);
        do_burst();
        check_stats();

        // frame 0 base, whole frame buffered up front
        start_frame(1'b0);
        repeat (OEND) push($urandom);
        do_burst();
        do_burst();
        check_stats();

        // underflow, then push+pop at count 10
        start_frame(1'b1);
        buf_re = 1'b1;
        step();
        buf_re = 1'b0;
        chk("underflow_set", {31'b0, underflow}, 32'd1);
        repeat (10) push($urandom);
        buf_re = 1'b1;
        push($urandom);
        buf_re = 1'b0;
        repeat (54) push($urandom);
        do_burst();
        repeat (AMT) push($urandom);
        do_burst();
        chk("underflow_sticky", {31'b0, underflow}, 32'd1);

        // overflow with engine stalled
        start_frame(1'b0);
        chk("underflow_clr", {31'b0, underflow}, 32'd0);
        busy = 1'b1;
        repeat (DEPTH) push($urandom);
        chk("ovf_before", {31'b0, overflow}, 32'd0);
        chk("kick_stalled", {31'b0, kick}, 32'd0);
        push($urandom);
        chk("ovf_after", {31'b0, overflow}, 32'd1);
        chk("prog_full", {31'b0, rgb_full}, 32'd1);
        check_stats();
        busy = 1'b0;
        do_burst();
        do_burst();
        check_stats();

        // async reset in the middle of a burst
        start_frame(1'b0);
        repeat (AMT) push($urandom);
        wait_kick();
        busy = 1'b1;
        step();
        buf_re = 1'b1;
        repeat (10) step();
        buf_re = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        exp_data.delete();
        exp_addr.delete();
        armed = 1'b0;
        frames_m = 0;
        drops_m = 0;
        chk("arst_kick", {31'b0, kick}, 32'd0);
        chk("arst_ready", {31'b0, ready}, 32'd0);
        chk("arst_ovf", {31'b0, overflow}, 32'd0);
        chk("arst_full", {31'b0, rgb_full}, 32'd0);
        chk("arst_addr", write_addr, 32'd0);
        check_stats();
        busy = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        start_frame(1'b1);
        repeat (OEND) push($urandom);
        do_burst();
        do_burst();
        check_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
